// File: rtl/xbus_ram_bridge_pkg.sv
// Shared xbus definitions for the RAM bridge and sibling xbus slaves.
//   xb_state_e    : bridge FSM states
//   XB_ADDR_W     : default xbus/SDRAM word address width
//   XB_RAM_TOP    : first address not backed by SDRAM (start of hole)
//   XB_DECODE_TOP : first address not decoded by the RAM slave at all
package xbus_ram_bridge_pkg;

  typedef enum logic [2:0] {
    XB_IDLE    = 3'd0,
    XB_RD      = 3'd1,
    XB_WR      = 3'd2,
    XB_HOLE    = 3'd3,
    XB_ACK     = 3'd4,
    XB_RELEASE = 3'd5
  } xb_state_e;

  localparam int unsigned           XB_ADDR_W     = 22;
  localparam logic [XB_ADDR_W-1:0] XB_RAM_TOP    = 22'o10000000;
  localparam logic [XB_ADDR_W-1:0] XB_DECODE_TOP = 22'o11000000;

endpackage

// File: rtl/xbus_ram_bridge_if.sv
// xbus RAM slave bundle: CPU-side xbus signals plus the SDRAM controller side.
//   slave  : the bridge (consumes xbus request and SDRAM responses)
//   master : the xbus arbiter / SDRAM controller side (or a bench)
//   xbus   : addr, datain, req, write -> ; <- dataout, ack, err, decode, busy
//   sdram  : <- sdram_addr, sdram_data_out, sdram_req, sdram_write
//            -> sdram_data_in, sdram_ready, sdram_done
interface xbus_ram_bridge_if #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] datain;
  logic              req;
  logic              write;
  logic [DATA_W-1:0] dataout;
  logic              ack;
  logic              err;
  logic              decode;
  logic              busy;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_data_out;
  logic [DATA_W-1:0] sdram_data_in;
  logic              sdram_req;
  logic              sdram_write;
  logic              sdram_ready;
  logic              sdram_done;

  modport slave (
    input  addr, datain, req, write, sdram_data_in, sdram_ready, sdram_done,
    output dataout, ack, err, decode, busy,
           sdram_addr, sdram_data_out, sdram_req, sdram_write
  );

  modport master (
    output addr, datain, req, write, sdram_data_in, sdram_ready, sdram_done,
    input  dataout, ack, err, decode, busy,
           sdram_addr, sdram_data_out, sdram_req, sdram_write
  );

endinterface

// File: rtl/xbus_ram_bridge_timeout.sv
// xbus_timeout: TO_W-bit clear/enable cycle counter with terminal-count flag.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : zero the counter (has priority over en)
//   en         : count this cycle
//   tc         : this is the TIMEOUT-th enabled cycle since clr
module xbus_timeout #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the enabled cycles already completed, so the current
  // cycle is number count_q+1; fire on the TIMEOUT-th one.
  assign tc = en && (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/xbus_ram_bridge.sv
// xbus_ram_bridge: registered xbus slave bridging CPU RAM accesses to SDRAM.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : xbus_ram_bridge_if.slave
//     addr/datain/req/write in; dataout/ack/err registered out
//     decode (comb, addr < DECODE_TOP), busy (state != IDLE)
//     sdram_addr/sdram_data_out captured at accept; sdram_req/sdram_write
//     level requests held until sdram_ready/sdram_done or timeout
// Addresses in [RAM_TOP, DECODE_TOP) form a hole that acks with no SDRAM
// access (reads return 0). A read/write that waits TIMEOUT cycles acks with
// err=1 (timed-out reads return all ones).
module xbus_ram_bridge
  import xbus_ram_bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W     = XB_ADDR_W,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RAM_TOP    = XB_RAM_TOP,
  parameter logic [ADDR_W-1:0] DECODE_TOP = XB_DECODE_TOP,
  parameter int unsigned       TIMEOUT    = 255,
  parameter int unsigned       TO_W       = 8
) (
  input logic              clk,
  input logic              reset,
  xbus_ram_bridge_if.slave bus
);

  xb_state_e state_q, state_d;

  logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
  logic [DATA_W-1:0] sdram_data_out_q, sdram_data_out_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              sdram_req_q, sdram_req_d;
  logic              sdram_write_q, sdram_write_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;

  logic decode_w;
  logic accept;
  logic hole;
  logic count_en;
  logic tc;

  assign decode_w = bus.addr < DECODE_TOP;
  assign accept   = (state_q == XB_IDLE) && bus.req && decode_w;
  assign hole     = bus.addr >= RAM_TOP;
  assign count_en = (state_q == XB_RD) || (state_q == XB_WR);

  xbus_timeout #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (count_en),
    .tc    (tc)
  );

  // State register and capture/output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= XB_IDLE;
      sdram_addr_q     <= '0;
      sdram_data_out_q <= '0;
      dataout_q        <= '0;
      sdram_req_q      <= 1'b0;
      sdram_write_q    <= 1'b0;
      ack_q            <= 1'b0;
      err_q            <= 1'b0;
      wr_q             <= 1'b0;
    end else begin
      state_q          <= state_d;
      sdram_addr_q     <= sdram_addr_d;
      sdram_data_out_q <= sdram_data_out_d;
      dataout_q        <= dataout_d;
      sdram_req_q      <= sdram_req_d;
      sdram_write_q    <= sdram_write_d;
      ack_q            <= ack_d;
      err_q            <= err_d;
      wr_q             <= wr_d;
    end
  end

  // Next-state logic. A completion in the terminal-count cycle still takes
  // the normal path; the output process gives it priority over the error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      XB_IDLE: begin
        if (accept) begin
          if (hole) begin
            state_d = XB_HOLE;
          end else if (bus.write) begin
            state_d = XB_WR;
          end else begin
            state_d = XB_RD;
          end
        end
      end
      XB_RD:      if (bus.sdram_ready || tc) state_d = XB_ACK;
      XB_WR:      if (bus.sdram_done || tc)  state_d = XB_ACK;
      XB_HOLE:    state_d = XB_ACK;
      XB_ACK:     state_d = XB_RELEASE;
      // Holding here until req drops stops a held req being taken twice.
      XB_RELEASE: if (!bus.req) state_d = XB_IDLE;
      default:    state_d = XB_IDLE;
    endcase
  end

  // Output/datapath logic. ack/err are computed on the edge that enters
  // ACK so they are registered and high for exactly the ACK cycle.
  always_comb begin
    sdram_addr_d     = sdram_addr_q;
    sdram_data_out_d = sdram_data_out_q;
    dataout_d        = dataout_q;
    sdram_req_d      = sdram_req_q;
    sdram_write_d    = sdram_write_q;
    wr_d             = wr_q;
    ack_d            = 1'b0;
    err_d            = 1'b0;
    case (state_q)
      XB_IDLE: begin
        if (accept) begin
          sdram_addr_d     = bus.addr;
          sdram_data_out_d = bus.datain;
          wr_d             = bus.write;
          sdram_req_d      = !hole && !bus.write;
          sdram_write_d    = !hole && bus.write;
        end
      end
      XB_RD: begin
        if (bus.sdram_ready) begin
          dataout_d   = bus.sdram_data_in;
          sdram_req_d = 1'b0;
          ack_d       = 1'b1;
        end else if (tc) begin
          dataout_d   = '1;
          sdram_req_d = 1'b0;
          ack_d       = 1'b1;
          err_d       = 1'b1;
        end
      end
      XB_WR: begin
        if (bus.sdram_done) begin
          sdram_write_d = 1'b0;
          ack_d         = 1'b1;
        end else if (tc) begin
          sdram_write_d = 1'b0;
          ack_d         = 1'b1;
          err_d         = 1'b1;
        end
      end
      XB_HOLE: begin
        ack_d = 1'b1;
        // Hole writes are dropped and leave dataout alone.
        if (!wr_q) begin
          dataout_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.dataout        = dataout_q;
  assign bus.ack            = ack_q;
  assign bus.err            = err_q;
  assign bus.decode         = decode_w;
  assign bus.busy           = (state_q != XB_IDLE);
  assign bus.sdram_addr     = sdram_addr_q;
  assign bus.sdram_data_out = sdram_data_out_q;
  assign bus.sdram_req      = sdram_req_q;
  assign bus.sdram_write    = sdram_write_q;

endmodule
